// File: rtl/franken_mem_arbiter.sv
// Arbitrates one variable-latency single-port memory between instruction fetch and data ports.
// Data has priority, bounded by a starvation counter; a watchdog aborts accesses that never see mem_ack.
module franken_mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        rbusy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [7:0]    WD_LIM     = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      D_WAIT,
      F_WAIT
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic [7:0]    wd_cnt, wd_nxt;

   logic        mem_req_nxt, mem_we_nxt;
   logic [31:0] mem_addr_nxt, mem_wdata_nxt;
   logic [3:0]  mem_be_nxt;
   logic [31:0] if_rdata_nxt, d_rdata_nxt;
   logic        if_valid_nxt, d_valid_nxt, err_nxt;

   logic d_elig, f_elig, fetch_wins;

   // A port whose valid is high is still holding the request it just had served.
   assign d_elig = d_req & ~d_valid;
   assign f_elig = if_req & ~if_valid;
   assign rbusy  = d_elig | f_elig;

   assign fetch_wins = f_elig & (~d_elig | (starve_cnt == STARVE_LIM));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         wd_cnt     <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         wd_cnt     <= wd_nxt;
         mem_req    <= mem_req_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         mem_be     <= mem_be_nxt;
         if_rdata   <= if_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
         if_valid   <= if_valid_nxt;
         d_valid    <= d_valid_nxt;
         err        <= err_nxt;
      end
   end

   // The IDLE cycle that carries a valid pulse never grants, so a continuously
   // requesting data port keeps competing and the starvation bound governs fetch.
   always_comb begin
      state_nxt     = state;
      starve_nxt    = starve_cnt;
      wd_nxt        = wd_cnt;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_be_nxt    = mem_be;
      if_rdata_nxt  = if_rdata;
      d_rdata_nxt   = d_rdata;
      if_valid_nxt  = 1'b0;
      d_valid_nxt   = 1'b0;
      err_nxt       = err;

      if (!f_elig) begin
         starve_nxt = '0;
      end

      case (state)
         IDLE: begin
            wd_nxt = '0;
            if (!if_valid && !d_valid && (d_elig || f_elig)) begin
               mem_req_nxt = 1'b1;
               wd_nxt      = 8'd1;
               if (fetch_wins) begin
                  state_nxt     = F_WAIT;
                  starve_nxt    = '0;
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = if_addr;
                  mem_wdata_nxt = '0;
                  mem_be_nxt    = 4'hF;
               end else begin
                  state_nxt     = D_WAIT;
                  mem_we_nxt    = d_we;
                  mem_addr_nxt  = d_addr;
                  mem_wdata_nxt = d_wdata;
                  mem_be_nxt    = d_be;
                  if (f_elig && (starve_cnt != STARVE_LIM)) begin
                     starve_nxt = starve_cnt + SW'(1);
                  end
               end
            end
         end

         D_WAIT, F_WAIT: begin
            if (mem_ack) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               wd_nxt      = '0;
               if (state == F_WAIT) begin
                  if_valid_nxt = 1'b1;
                  if_rdata_nxt = mem_rdata;
               end else begin
                  d_valid_nxt = 1'b1;
                  if (!mem_we) begin
                     d_rdata_nxt = mem_rdata;
                  end
               end
            end else if (wd_cnt == WD_LIM) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               wd_nxt      = '0;
               err_nxt     = 1'b1;
               if (state == F_WAIT) begin
                  if_valid_nxt = 1'b1;
                  if_rdata_nxt = '0;
               end else begin
                  d_valid_nxt = 1'b1;
                  d_rdata_nxt = '0;
               end
            end else begin
               wd_nxt = wd_cnt + 8'd1;
            end
         end

         default: begin
            state_nxt   = IDLE;
            mem_req_nxt = 1'b0;
         end
      endcase
   end

endmodule
